// File: rtl/pc_unit.sv
// Program counter for the 6502 core: PCL/PCH with increment, byte loads and
// relative branches whose page crossings take one extra PCH fix-up cycle.
module pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic       phi1,
    input  logic       reset,
    input  logic       inc_EN,
    input  logic       loadL_EN,
    input  logic       loadH_EN,
    input  logic [7:0] addressLowBus_IN,
    input  logic [7:0] addressHighBus_IN,
    input  logic       branch_EN,
    input  logic [7:0] offset_IN,
    output logic [7:0] pcl_OUT,
    output logic [7:0] pch_OUT,
    output logic       pageCross_OUT,
    output logic       dbg_state_OUT
);

    // Command protocol: a command is accepted on any posedge phi1 where
    // pageCross_OUT is low; while it is high the unit is busy and drops commands.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FIXUP = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ADJ_NONE = 2'b00,
        ADJ_INC  = 2'b01,
        ADJ_DEC  = 2'b10
    } adj_t;

    state_t     state_q, state_d;
    adj_t       adj_h_q, adj_h_d;
    logic [7:0] pcl_q, pcl_d;
    logic [7:0] pch_q, pch_d;
    logic       page_cross_q, page_cross_d;

    logic [8:0] sum9;
    logic [8:0] inc9;
    logic       any_load;

    always_comb begin
        sum9     = {1'b0, pcl_q} + {1'b0, offset_IN};
        inc9     = {1'b0, pcl_q} + 9'd1;
        any_load = loadL_EN | loadH_EN;
    end

    always_comb begin
        state_d      = state_q;
        adj_h_d      = adj_h_q;
        pcl_d        = pcl_q;
        pch_d        = pch_q;
        page_cross_d = page_cross_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_load) begin
                    if (loadL_EN) pcl_d = addressLowBus_IN;
                    if (loadH_EN) pch_d = addressHighBus_IN;
                end else if (branch_EN) begin
                    pcl_d = sum9[7:0];
                    // Carry out of a positive offset or no carry from a negative one
                    // means the target lies in a neighbouring page.
                    if (!offset_IN[7] && sum9[8]) begin
                        adj_h_d      = ADJ_INC;
                        state_d      = ST_FIXUP;
                        page_cross_d = 1'b1;
                    end else if (offset_IN[7] && !sum9[8]) begin
                        adj_h_d      = ADJ_DEC;
                        state_d      = ST_FIXUP;
                        page_cross_d = 1'b1;
                    end
                end else if (inc_EN) begin
                    pcl_d = inc9[7:0];
                    pch_d = pch_q + {7'd0, inc9[8]};
                end
            end
            ST_FIXUP: begin
                unique case (adj_h_q)
                    ADJ_INC: pch_d = pch_q + 8'd1;
                    ADJ_DEC: pch_d = pch_q - 8'd1;
                    default: pch_d = pch_q;
                endcase
                adj_h_d      = ADJ_NONE;
                state_d      = ST_IDLE;
                page_cross_d = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                adj_h_d      = ADJ_NONE;
                page_cross_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            adj_h_q      <= ADJ_NONE;
            pcl_q        <= RESET_PC[7:0];
            pch_q        <= RESET_PC[15:8];
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            adj_h_q      <= adj_h_d;
            pcl_q        <= pcl_d;
            pch_q        <= pch_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign pcl_OUT       = pcl_q;
    assign pch_OUT       = pch_q;
    assign pageCross_OUT = page_cross_q;
    assign dbg_state_OUT = state_q;

endmodule
